// File: rtl/ps2_host_cmd.sv
// Purpose : PS/2 keyboard host-command handler; decodes host bytes, queues ACK/echo/ID/BAT replies, owns LED/scan/typematic state.
// Latency : rx_valid in cycle N -> tx_valid in cycle N+1; BAT_CYCLES cycles in BAT_WAIT before the 0xAA byte.
// Backpressure: tx_data held while tx_valid & !tx_ready; a new host byte during a reply aborts the rest of the reply.
//
// Ports:
//   clock_50, rst_n             clock, synchronous active-low reset
//   rx_valid/rx_data/rx_error   host byte strobe, byte, framing-error strobe
//   tx_ready/tx_valid/tx_data   reply byte handshake toward the device-side transmitter
//   scroll_lock/num_lock/caps_lock, scan_enable, typematic   exported configuration
//   busy                        FSM is not in IDLE
module ps2_host_cmd #(
    parameter int unsigned BAT_CYCLES        = 25_000_000,
    parameter logic [6:0]  TYPEMATIC_DEFAULT = 7'h2B
) (
    input  logic       clock_50,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       scroll_lock,
    output logic       num_lock,
    output logic       caps_lock,
    output logic       scan_enable,
    output logic [6:0] typematic,
    output logic       busy
);

    localparam int unsigned      CNT_W   = (BAT_CYCLES > 1) ? $clog2(BAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ARG,
        S_SEND,
        S_BAT_WAIT
    } state_t;

    state_t           state_q;
    state_t           after_q;      // where SEND returns once the list is drained
    logic [2:0][7:0]  list_q;
    logic [1:0]       len_q;
    logic [1:0]       idx_q;
    logic             from_fe_q;    // current list answers a resend request
    logic             owner_f3_q;   // pending argument belongs to F3 (else ED)
    logic [7:0]       last_sent_q;
    logic [CNT_W-1:0] bat_cnt_q;
    logic             pend_q;       // host byte deferred out of SEND
    logic [7:0]       pend_dat_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;
    logic [2:0]       leds_q;       // {caps, num, scroll}
    logic             scan_q;
    logic [6:0]       typ_q;

    logic       consume;
    logic [1:0] idx_nxt;
    logic       in_vld;
    logic [7:0] in_dat;

    assign consume = tx_valid_q & tx_ready;
    assign idx_nxt = idx_q + 2'd1;
    // A byte deferred out of SEND is replayed next cycle as if it had just arrived.
    assign in_vld  = pend_q | rx_valid;
    assign in_dat  = pend_q ? pend_dat_q : rx_data;

    // Command decode of in_dat
    logic [2:0][7:0] dec_list;
    logic [1:0]      dec_len;
    state_t          dec_after;
    logic            dec_from_fe;
    logic            dec_scan_on;
    logic            dec_scan_off;
    logic            dec_typ_dflt;
    logic            dec_restart;

    always_comb begin
        dec_list     = {8'h00, 8'h00, 8'hFA};
        dec_len      = 2'd1;
        dec_after    = S_IDLE;
        dec_from_fe  = 1'b0;
        dec_scan_on  = 1'b0;
        dec_scan_off = 1'b0;
        dec_typ_dflt = 1'b0;
        dec_restart  = 1'b0;
        case (in_dat)
            8'hED, 8'hF3: dec_after = S_WAIT_ARG;
            8'hEE:        dec_list[0] = 8'hEE;
            8'hF2: begin
                dec_list = {8'h83, 8'hAB, 8'hFA};
                dec_len  = 2'd3;
            end
            8'hF4:        dec_scan_on = 1'b1;
            8'hF5: begin
                dec_scan_off = 1'b1;
                dec_typ_dflt = 1'b1;
            end
            8'hF6: begin
                dec_scan_on  = 1'b1;
                dec_typ_dflt = 1'b1;
            end
            8'hFE: begin
                dec_list[0] = last_sent_q;
                dec_from_fe = 1'b1;
            end
            8'hFF: begin
                dec_restart = 1'b1;
                dec_after   = S_BAT_WAIT;
            end
            default:      dec_list[0] = 8'hFE;
        endcase
    end

    // Decide what this cycle does: load a new reply list, defer a byte, or nothing
    logic            ld_en;
    logic            ld_cmd;
    logic            ld_arg;
    logic            defer;
    logic [2:0][7:0] ld_list;
    logic [1:0]      ld_len;
    state_t          ld_after;
    logic            ld_from_fe;

    always_comb begin
        ld_en      = 1'b0;
        ld_cmd     = 1'b0;
        ld_arg     = 1'b0;
        defer      = 1'b0;
        ld_list    = dec_list;
        ld_len     = dec_len;
        ld_after   = dec_after;
        ld_from_fe = dec_from_fe;
        case (state_q)
            S_BAT_WAIT: begin
                // Only a reset command is honoured while the self-test runs.
                if (in_vld && in_dat == 8'hFF) begin
                    ld_en  = 1'b1;
                    ld_cmd = 1'b1;
                end else if (bat_cnt_q == CNT_MAX) begin
                    ld_en      = 1'b1;
                    ld_list    = {8'h00, 8'h00, 8'hAA};
                    ld_len     = 2'd1;
                    ld_after   = S_IDLE;
                    ld_from_fe = 1'b0;
                end
            end
            S_SEND: begin
                if (rx_error) begin
                    ld_en      = 1'b1;
                    ld_list    = {8'h00, 8'h00, 8'hFE};
                    ld_len     = 2'd1;
                    ld_after   = S_IDLE;
                    ld_from_fe = 1'b0;
                end else if (rx_valid) begin
                    defer = 1'b1;
                end
            end
            default: begin
                if (rx_error) begin
                    ld_en      = 1'b1;
                    ld_list    = {8'h00, 8'h00, 8'hFE};
                    ld_len     = 2'd1;
                    ld_after   = S_IDLE;
                    ld_from_fe = 1'b0;
                end else if (in_vld) begin
                    ld_en = 1'b1;
                    // A byte with bit 7 set abandons the argument and is decoded as a command.
                    if (state_q == S_WAIT_ARG && !in_dat[7]) begin
                        ld_arg     = 1'b1;
                        ld_list    = {8'h00, 8'h00, 8'hFA};
                        ld_len     = 2'd1;
                        ld_after   = S_IDLE;
                        ld_from_fe = 1'b0;
                    end else begin
                        ld_cmd = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (!rst_n) begin
            state_q     <= S_BAT_WAIT;
            after_q     <= S_IDLE;
            list_q      <= '0;
            len_q       <= 2'd0;
            idx_q       <= 2'd0;
            from_fe_q   <= 1'b0;
            owner_f3_q  <= 1'b0;
            last_sent_q <= 8'hAA;
            bat_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_dat_q  <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            leds_q      <= 3'b000;
            scan_q      <= 1'b1;
            typ_q       <= TYPEMATIC_DEFAULT;
        end else begin
            pend_q <= defer;
            if (defer) begin
                pend_dat_q <= rx_data;
            end
            if (consume && !from_fe_q) begin
                last_sent_q <= tx_data_q;
            end
            // Saturating self-test timer; only a 0xFF command rewinds it.
            if (state_q == S_BAT_WAIT && bat_cnt_q != CNT_MAX) begin
                bat_cnt_q <= bat_cnt_q + 1'b1;
            end

            if (ld_en) begin
                state_q    <= S_SEND;
                after_q    <= ld_after;
                list_q     <= ld_list;
                len_q      <= ld_len;
                idx_q      <= 2'd0;
                from_fe_q  <= ld_from_fe;
                tx_valid_q <= 1'b1;
                tx_data_q  <= ld_list[0];
            end else if (defer) begin
                // Remainder of the reply is dropped; the new byte is handled next cycle.
                state_q    <= after_q;
                tx_valid_q <= 1'b0;
            end else if (consume) begin
                if (idx_nxt < len_q) begin
                    idx_q     <= idx_nxt;
                    tx_data_q <= list_q[idx_nxt];
                end else begin
                    state_q    <= after_q;
                    tx_valid_q <= 1'b0;
                end
            end

            if (ld_cmd) begin
                if (dec_after == S_WAIT_ARG) begin
                    owner_f3_q <= (in_dat == 8'hF3);
                end
                if (dec_scan_on) begin
                    scan_q <= 1'b1;
                end
                if (dec_scan_off) begin
                    scan_q <= 1'b0;
                end
                if (dec_typ_dflt) begin
                    typ_q <= TYPEMATIC_DEFAULT;
                end
                if (dec_restart) begin
                    leds_q    <= 3'b000;
                    scan_q    <= 1'b1;
                    typ_q     <= TYPEMATIC_DEFAULT;
                    bat_cnt_q <= '0;
                end
            end
            if (ld_arg) begin
                if (owner_f3_q) begin
                    typ_q <= in_dat[6:0];
                end else begin
                    leds_q <= in_dat[2:0];
                end
            end
        end
    end

    assign tx_valid                          = tx_valid_q;
    assign tx_data                           = tx_data_q;
    assign {caps_lock, num_lock, scroll_lock} = leds_q;
    assign scan_enable                       = scan_q;
    assign typematic                         = typ_q;
    assign busy                              = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Purpose : directed bench for ps2_host_cmd with a queue-based reply model checked every cycle.
// Latency : model predicts outputs after each clock edge; compared on the falling edge.
// Backpressure: tx_ready driven by the stimulus to hold and release reply bytes.
module tb_ps2_host_cmd;

    localparam int BAT = 8;
    localparam int M_IDLE = 0;
    localparam int M_ARG  = 1;
    localparam int M_BAT  = 2;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       scroll_lock, num_lock, caps_lock, scan_enable, busy;
    logic [6:0] typematic;

    int n_cmp  = 0;
    int n_fail = 0;

    ps2_host_cmd #(.BAT_CYCLES(BAT), .TYPEMATIC_DEFAULT(7'h2B)) dut (
        .clock_50   (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_error   (rx_error),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .scroll_lock(scroll_lock),
        .num_lock   (num_lock),
        .caps_lock  (caps_lock),
        .scan_enable(scan_enable),
        .typematic  (typematic),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];          // reply bytes still to go out, front is on the bus
    bit         m_show;
    int         m_mode;         // where the handler rests once the queue is empty
    bit         m_own_f3;
    bit         m_from_fe;
    logic [7:0] m_last;
    logic [2:0] m_leds;
    bit         m_scan;
    logic [6:0] m_typ;
    int         m_bat;
    bit         m_pend;
    logic [7:0] m_pbyte;
    bit         m_started = 1'b0;
    logic [7:0] m_front;

    task automatic m_reply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int n, input int rest, input bit ffe);
        mq.delete();
        mq.push_back(b0);
        if (n > 1) mq.push_back(b1);
        if (n > 2) mq.push_back(b2);
        m_show    = 1'b1;
        m_mode    = rest;
        m_from_fe = ffe;
    endtask

    task automatic m_cmd(input logic [7:0] b);
        case (b)
            8'hED: begin m_own_f3 = 1'b0; m_reply(8'hFA, 0, 0, 1, M_ARG, 0); end
            8'hF3: begin m_own_f3 = 1'b1; m_reply(8'hFA, 0, 0, 1, M_ARG, 0); end
            8'hEE: m_reply(8'hEE, 0, 0, 1, M_IDLE, 0);
            8'hF2: m_reply(8'hFA, 8'hAB, 8'h83, 3, M_IDLE, 0);
            8'hF4: begin m_scan = 1'b1; m_reply(8'hFA, 0, 0, 1, M_IDLE, 0); end
            8'hF5: begin m_scan = 1'b0; m_typ = 7'h2B; m_reply(8'hFA, 0, 0, 1, M_IDLE, 0); end
            8'hF6: begin m_scan = 1'b1; m_typ = 7'h2B; m_reply(8'hFA, 0, 0, 1, M_IDLE, 0); end
            8'hFE: m_reply(m_last, 0, 0, 1, M_IDLE, 1);
            8'hFF: begin
                m_leds = 3'b000; m_scan = 1'b1; m_typ = 7'h2B; m_bat = 0;
                m_reply(8'hFA, 0, 0, 1, M_BAT, 0);
            end
            default: m_reply(8'hFE, 0, 0, 1, M_IDLE, 0);
        endcase
    endtask

    task automatic m_step();
        bit         had_pend;
        logic [7:0] pb;
        logic [7:0] b;
        if (!rst_n) begin
            mq.delete();
            m_show = 0; m_mode = M_BAT; m_bat = 0; m_last = 8'hAA;
            m_leds = 3'b000; m_scan = 1'b1; m_typ = 7'h2B;
            m_pend = 0; m_pbyte = 8'h00; m_from_fe = 0; m_own_f3 = 0;
            return;
        end
        had_pend = m_pend;
        pb       = m_pbyte;
        m_pend   = 1'b0;
        if (m_show) begin
            if (tx_ready) begin
                if (!m_from_fe) m_last = mq[0];
                void'(mq.pop_front());
            end
            if (rx_error) begin
                m_reply(8'hFE, 0, 0, 1, M_IDLE, 0);
            end else if (rx_valid) begin
                mq.delete();
                m_show  = 1'b0;
                m_pend  = 1'b1;
                m_pbyte = rx_data;
            end else if (mq.size() == 0) begin
                m_show = 1'b0;
            end
        end else if (m_mode == M_BAT) begin
            if ((had_pend && pb == 8'hFF) || (!had_pend && rx_valid && rx_data == 8'hFF)) begin
                m_cmd(8'hFF);
            end else begin
                m_bat++;
                if (m_bat == BAT) m_reply(8'hAA, 0, 0, 1, M_IDLE, 0);
            end
        end else begin
            if (rx_error) begin
                m_reply(8'hFE, 0, 0, 1, M_IDLE, 0);
            end else if (had_pend || rx_valid) begin
                b = had_pend ? pb : rx_data;
                if (m_mode == M_ARG && !b[7]) begin
                    if (m_own_f3) m_typ = b[6:0];
                    else          m_leds = b[2:0];
                    m_reply(8'hFA, 0, 0, 1, M_IDLE, 0);
                end else begin
                    m_cmd(b);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        m_step();
        m_started = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            m_front = (m_show && mq.size() > 0) ? mq[0] : 8'h00;
            n_cmp++;
            if (tx_valid !== m_show || (m_show && tx_data !== m_front) ||
                {caps_lock, num_lock, scroll_lock} !== m_leds || scan_enable !== m_scan ||
                typematic !== m_typ || busy !== (m_show || m_mode != M_IDLE)) begin
                n_fail++;
                $display("FAIL model t=%0t: dut vld=%b dat=%h led=%b scan=%b typ=%h busy=%b / model vld=%b dat=%h led=%b scan=%b typ=%h busy=%b",
                         $time, tx_valid, tx_data, {caps_lock, num_lock, scroll_lock}, scan_enable, typematic, busy,
                         m_show, m_front, m_leds, m_scan, m_typ, (m_show || m_mode != M_IDLE));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_err();
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
    endtask

    // Releases tx_ready and checks the next n bytes handed over.
    task automatic expect_bytes(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input int n);
        logic [7:0] e[3];
        int k;
        e = '{b0, b1, b2};
        k = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 40 && k < n; c++) begin
            if (tx_valid) begin
                chk(name, tx_data, e[k]);
                k++;
            end
            tick();
        end
        if (k < n) chk({name, " timeout"}, k, n);
    endtask

    // Counts falling edges until tx_valid rises (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!tx_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    int cnt;
    int nbytes;
    logic [7:0] got;

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0; tx_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 8'h00);
        chk("rst leds", {caps_lock, num_lock, scroll_lock}, 3'b000);
        chk("rst scan", scan_enable, 1);
        chk("rst typ", typematic, 7'h2B);
        rst_n = 1'b1;
        wait_valid(cnt);
        chk("bat latency", cnt, 8);
        expect_bytes("bat byte", 8'hAA, 0, 0, 1);

        // LED set
        send(8'hED);
        chk("ed latency", tx_valid, 1);
        expect_bytes("ed ack", 8'hFA, 0, 0, 1);
        send(8'h05);
        expect_bytes("led ack", 8'hFA, 0, 0, 1);
        chk("leds 101", {caps_lock, num_lock, scroll_lock}, 3'b101);
        chk("idle after led", busy, 0);

        // ID with backpressure
        tx_ready = 1'b0;
        send(8'hF2);
        for (int i = 0; i < 10; i++) begin
            chk("f2 hold", {tx_valid, tx_data}, {1'b1, 8'hFA});
            tick();
        end
        expect_bytes("f2 id", 8'hFA, 8'hAB, 8'h83, 3);

        // Abandoned argument, scan enable/disable, typematic
        send(8'hED);
        expect_bytes("ed2 ack", 8'hFA, 0, 0, 1);
        send(8'hF4);
        expect_bytes("f4 ack", 8'hFA, 0, 0, 1);
        chk("leds kept", {caps_lock, num_lock, scroll_lock}, 3'b101);
        chk("scan on", scan_enable, 1);
        chk("idle after f4", busy, 0);
        send(8'hF5);
        expect_bytes("f5 ack", 8'hFA, 0, 0, 1);
        chk("scan off", scan_enable, 0);
        send(8'hF3);
        expect_bytes("f3 ack", 8'hFA, 0, 0, 1);
        send(8'h15);
        expect_bytes("rate ack", 8'hFA, 0, 0, 1);
        chk("typ set", typematic, 7'h15);
        send(8'hF6);
        expect_bytes("f6 ack", 8'hFA, 0, 0, 1);
        chk("f6 typ", typematic, 7'h2B);
        chk("f6 scan", scan_enable, 1);

        // Echo, resend, unknown, framing error
        send(8'hEE);
        expect_bytes("echo", 8'hEE, 0, 0, 1);
        send(8'hFE);
        expect_bytes("resend", 8'hEE, 0, 0, 1);
        send(8'h42);
        expect_bytes("unknown", 8'hFE, 0, 0, 1);
        send_err();
        expect_bytes("rx error", 8'hFE, 0, 0, 1);

        // Host byte arrives while a reply is stalled
        tx_ready = 1'b0;
        send(8'hF2);
        tick();
        send(8'hEE);
        chk("abort gap", tx_valid, 0);
        tick();
        chk("abort new", {tx_valid, tx_data}, {1'b1, 8'hEE});
        expect_bytes("abort echo", 8'hEE, 0, 0, 1);

        // Reset command
        send(8'hED);
        expect_bytes("ed3 ack", 8'hFA, 0, 0, 1);
        send(8'h07);
        expect_bytes("led7 ack", 8'hFA, 0, 0, 1);
        chk("leds 111", {caps_lock, num_lock, scroll_lock}, 3'b111);
        send(8'hFF);
        chk("ff ack", {tx_valid, tx_data}, {1'b1, 8'hFA});
        chk("ff leds", {caps_lock, num_lock, scroll_lock}, 3'b000);
        tick();
        wait_valid(cnt);
        chk("ff bat latency", cnt + 1, 9);
        expect_bytes("ff bat", 8'hAA, 0, 0, 1);

        // FF during self-test restarts it; other input ignored
        send(8'hFF);
        expect_bytes("ff2 ack", 8'hFA, 0, 0, 1);
        tick();
        send_err();
        send(8'h42);
        chk("bat ignores", tx_valid, 0);
        send(8'hFF);
        chk("bat ff ack", {tx_valid, tx_data}, {1'b1, 8'hFA});
        tick();
        wait_valid(cnt);
        chk("restart latency", cnt + 1, 9);
        expect_bytes("restart bat", 8'hAA, 0, 0, 1);

        // Reset in the middle of a reply
        tx_ready = 1'b0;
        send(8'hF2);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst mid vld", tx_valid, 0);
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        nbytes = 0;
        got = 8'h00;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid) begin
                nbytes++;
                got = tx_data;
            end
            tick();
        end
        chk("post rst count", nbytes, 1);
        chk("post rst byte", got, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
